control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle fetch/decode/execute sequencer for the J17 core. Fetches 32-bit instruction words over a request/acknowledge handshake, decodes them, and drives the datapath control inputs (opcode, op1, op2, imControl, regenable, ramenable, pcControl, writecode) for exactly one execute step per instruction. Also keeps a retired-instruction counter and traps illegal instructions into a halt state.

## Interface
- No parameters; all widths fixed.
- clock  in  1  processor clock; everything updates on its rising edge.
- resetn  in  1  synchronous, active-low reset; one clock, reset is synchronous and active-low.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  instruction valid; imem_instr is sampled on the edge where req && ack.
- imem_instr  in  32  instruction word.
- opcode  out  4  ALU operation to the datapath.
- op1  out  32  destination/first register index, zero-extended.
- op2  out  32  second register index or immediate, zero-extended.
- imControl  out  1  1 = op2 is an immediate.
- regenable  out  1  register write strobe.
- ramenable  out  1  RAM address enable.
- ramwrite  out  1  RAM write strobe.
- pcControl  out  2  0 = PC+1, 1 = load op2, 2 = hold.
- writecode  out  2  register write source: 0 = ALU, 1 = op2, 2 = RAM.
- retired  out  32  count of completed instructions.
- halted  out  1  core stopped (HALT or illegal).
- illegal  out  1  sticky; set when an undefined major op is decoded.

## Operation
- Instruction format: [31:28] major op, [27:24] ALU opcode, [23:19] rd, [18:14] rs, [18:0] imm19.
- op1 = {27'b0, rd}. op2 = {27'b0, rs} for major 0; otherwise {13'b0, imm19}.
- Major ops:
  - 0 ALU reg: imControl=0, writecode=0, regenable.
  - 1 ALU imm: imControl=1, writecode=0, regenable.
  - 2 LI: writecode=1, regenable.
  - 3 LOAD: ramenable in EXEC; ramenable + regenable with writecode=2 in MEM.
  - 4 STORE: ramenable + ramwrite in EXEC.
  - 5 JMP: pcControl=1.
  - 6 NOP.
  - 7 HALT.
  - 8..15 illegal: set illegal, go to HALT, and do not count as retired.
- States: FETCH, DECODE, EXEC, MEM, HALT.
  - FETCH: imem_req=1. On ack, latch instr, then DECODE.
  - DECODE: outputs stay idle; register the decoded fields, then EXEC. An illegal op goes to HALT instead.
  - EXEC: assert the strobes. LOAD goes to MEM; HALT goes to HALT; everything else goes to FETCH.
  - MEM: then FETCH.
  - HALT: terminal; only resetn leaves it.
- Idle output values (FETCH, DECODE, HALT, and reset): regenable, ramenable and ramwrite = 0; pcControl = 2; writecode = 0; imControl = 0; opcode, op1 and op2 hold their last decoded values (0 after reset).
- pcControl is 0 or 1 for exactly one cycle per instruction:
  - the EXEC cycle for every op except LOAD and HALT;
  - the MEM cycle for LOAD;
  - never for HALT or illegal ops.
- retired increments by 1 in the same cycle as that pcControl step, and also on entry to HALT via op 7. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset: state = FETCH with imem_req = 0 during the reset cycle. All outputs are at their idle values, retired = 0, halted = 0, illegal = 0. imem_req rises in the first cycle after resetn is high.
- Reset mid-instruction aborts the instruction with no strobe issued. Reset dominates every other event.
- imem_req stays high until ack, then drops in the cycle after the capture edge. If ack is asserted while req is low, it is ignored.
- Latency from the ack edge: DECODE for 1 cycle, then EXEC for 1 cycle. A new imem_req rises 2 cycles after ack for non-load ops and 3 cycles after ack for LOAD.
- Throughput with ack tied high: 3 cycles per instruction, 4 for LOAD.
- halted rises in the cycle after EXEC of HALT, or in the cycle after DECODE of an illegal op.

## Test plan
- Reset then ack=1 with instr 0x1_1_08_0005 (ALU imm add, rd=1, imm=5) -> EXEC cycle 2 after ack shows opcode=1, op1=1, op2=5, imControl=1, regenable=1, pcControl=0; retired=1.
- LOAD 0x3_0_10_0040 -> EXEC: ramenable=1, regenable=0, pcControl=2. MEM: ramenable=1, regenable=1, writecode=2, pcControl=0. Next imem_req 3 cycles after ack.
- JMP imm 0x20 -> pcControl=1 and op2=0x20 for one cycle. STORE -> ramwrite=1, regenable=0.
- ack delayed 4 cycles -> imem_req held for 5 cycles, all strobes 0 and pcControl=2 throughout.
- Illegal major 0xA -> illegal=1, halted=1, retired unchanged, imem_req stays 0. resetn low for one cycle -> illegal=0 and fetching resumes.
- resetn low during EXEC of an ALU op -> no regenable/pcControl strobe on the following cycles, and retired=0.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the J17 core.
// Each instruction produces one registered execute step of datapath controls.
module control_unit (
    input  logic        clock,
    input  logic        resetn,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_instr,
    output logic [3:0]  opcode,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic        imControl,
    output logic        regenable,
    output logic        ramenable,
    output logic        ramwrite,
    output logic [1:0]  pcControl,
    output logic [1:0]  writecode,
    output logic [31:0] retired,
    output logic        halted,
    output logic        illegal
);
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    localparam logic [3:0] OP_ALU_REG = 4'd0;
    localparam logic [3:0] OP_ALU_IMM = 4'd1;
    localparam logic [3:0] OP_LI      = 4'd2;
    localparam logic [3:0] OP_LOAD    = 4'd3;
    localparam logic [3:0] OP_STORE   = 4'd4;
    localparam logic [3:0] OP_JMP     = 4'd5;
    localparam logic [3:0] OP_NOP     = 4'd6;
    localparam logic [3:0] OP_HALT    = 4'd7;

    localparam logic [1:0] PC_NEXT = 2'd0;
    localparam logic [1:0] PC_LOAD = 2'd1;
    localparam logic [1:0] PC_HOLD = 2'd2;
    localparam logic [1:0] WC_ALU  = 2'd0;
    localparam logic [1:0] WC_OP2  = 2'd1;
    localparam logic [1:0] WC_RAM  = 2'd2;

    logic [2:0]  state_r;
    logic [2:0]  state_s;
    logic [31:0] instr_r;
    logic [31:0] instr_s;
    logic [3:0]  major_s;
    logic        req_s;
    logic        imc_s;
    logic        regen_s;
    logic        ramen_s;
    logic        ramwr_s;
    logic [1:0]  pc_s;
    logic [1:0]  wc_s;
    logic [3:0]  opcode_s;
    logic [31:0] op1_s;
    logic [31:0] op2_s;
    logic        retire_s;
    logic        halted_s;
    logic        illegal_s;

    assign major_s = instr_r[31:28];

    // Next-state and next-output computation; outputs are registered so every
    // strobe value here becomes visible in the state being entered.
    always_comb begin
        state_s   = state_r;
        instr_s   = instr_r;
        req_s     = 1'b0;
        imc_s     = 1'b0;
        regen_s   = 1'b0;
        ramen_s   = 1'b0;
        ramwr_s   = 1'b0;
        pc_s      = PC_HOLD;
        wc_s      = WC_ALU;
        opcode_s  = opcode;
        op1_s     = op1;
        op2_s     = op2;
        retire_s  = 1'b0;
        halted_s  = halted;
        illegal_s = illegal;
        case (state_r)
            ST_FETCH: begin
                if (imem_req && imem_ack) begin
                    state_s = ST_DECODE;
                    instr_s = imem_instr;
                end else begin
                    req_s = 1'b1;
                end
            end
            ST_DECODE: begin
                if (major_s[3]) begin
                    state_s   = ST_HALT;
                    halted_s  = 1'b1;
                    illegal_s = 1'b1;
                end else begin
                    state_s  = ST_EXEC;
                    opcode_s = instr_r[27:24];
                    op1_s    = {27'd0, instr_r[23:19]};
                    if (major_s == OP_ALU_REG) begin
                        op2_s = {27'd0, instr_r[18:14]};
                    end else begin
                        op2_s = {13'd0, instr_r[18:0]};
                    end
                    case (major_s)
                        OP_ALU_REG: begin
                            regen_s = 1'b1;
                            pc_s    = PC_NEXT;
                        end
                        OP_ALU_IMM: begin
                            imc_s   = 1'b1;
                            regen_s = 1'b1;
                            pc_s    = PC_NEXT;
                        end
                        OP_LI: begin
                            wc_s    = WC_OP2;
                            regen_s = 1'b1;
                            pc_s    = PC_NEXT;
                        end
                        OP_LOAD: begin
                            ramen_s = 1'b1;
                        end
                        OP_STORE: begin
                            ramen_s = 1'b1;
                            ramwr_s = 1'b1;
                            pc_s    = PC_NEXT;
                        end
                        OP_JMP: begin
                            pc_s = PC_LOAD;
                        end
                        OP_NOP: begin
                            pc_s = PC_NEXT;
                        end
                        default: begin
                            pc_s = PC_HOLD;
                        end
                    endcase
                    // LOAD retires in MEM and HALT on entry to the halt state
                    retire_s = (major_s != OP_LOAD) && (major_s != OP_HALT);
                end
            end
            ST_EXEC: begin
                if (major_s == OP_LOAD) begin
                    state_s  = ST_MEM;
                    ramen_s  = 1'b1;
                    regen_s  = 1'b1;
                    wc_s     = WC_RAM;
                    pc_s     = PC_NEXT;
                    retire_s = 1'b1;
                end else if (major_s == OP_HALT) begin
                    state_s  = ST_HALT;
                    halted_s = 1'b1;
                    retire_s = 1'b1;
                end else begin
                    state_s = ST_FETCH;
                    req_s   = 1'b1;
                end
            end
            ST_MEM: begin
                state_s = ST_FETCH;
                req_s   = 1'b1;
            end
            ST_HALT: begin
                state_s = ST_HALT;
            end
            default: begin
                state_s = ST_FETCH;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r   <= ST_FETCH;
            instr_r   <= 32'd0;
            imem_req  <= 1'b0;
            imControl <= 1'b0;
            regenable <= 1'b0;
            ramenable <= 1'b0;
            ramwrite  <= 1'b0;
            pcControl <= PC_HOLD;
            writecode <= WC_ALU;
            opcode    <= 4'd0;
            op1       <= 32'd0;
            op2       <= 32'd0;
            retired   <= 32'd0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state_r   <= state_s;
            instr_r   <= instr_s;
            imem_req  <= req_s;
            imControl <= imc_s;
            regenable <= regen_s;
            ramenable <= ramen_s;
            ramwrite  <= ramwr_s;
            pcControl <= pc_s;
            writecode <= wc_s;
            opcode    <= opcode_s;
            op1       <= op1_s;
            op2       <= op2_s;
            retired   <= retire_s ? (retired + 32'd1) : retired;
            halted    <= halted_s;
            illegal   <= illegal_s;
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit against a per-instruction schedule model.
module tb_control_unit;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_instr = 32'd0;
    logic        imem_req;
    logic [3:0]  opcode;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        imControl;
    logic        regenable;
    logic        ramenable;
    logic        ramwrite;
    logic [1:0]  pcControl;
    logic [1:0]  writecode;
    logic [31:0] retired;
    logic        halted;
    logic        illegal;

    control_unit dut (
        .clock(clock), .resetn(resetn), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_instr(imem_instr), .opcode(opcode), .op1(op1), .op2(op2),
        .imControl(imControl), .regenable(regenable), .ramenable(ramenable),
        .ramwrite(ramwrite), .pcControl(pcControl), .writecode(writecode),
        .retired(retired), .halted(halted), .illegal(illegal)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [3:0]  m_opcode;
    logic [31:0] m_op1;
    logic [31:0] m_op2;
    logic [31:0] m_retired;
    logic        m_halted;
    logic        m_illegal;

    function automatic logic [127:0] pack(input logic req, input logic [3:0] opc,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic imc, input logic rg, input logic re,
                                          input logic rw, input logic [1:0] pc,
                                          input logic [1:0] wc, input logic [31:0] ret,
                                          input logic h, input logic il);
        return {17'd0, req, opc, a, b, imc, rg, re, rw, pc, wc, ret, h, il};
    endfunction

    function automatic logic [127:0] observed();
        return pack(imem_req, opcode, op1, op2, imControl, regenable, ramenable, ramwrite,
                    pcControl, writecode, retired, halted, illegal);
    endfunction

    function automatic logic [127:0] exp_idle(input logic req);
        return pack(req, m_opcode, m_op1, m_op2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0,
                    m_retired, m_halted, m_illegal);
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic noise();
        imem_ack   = 1'($urandom_range(0, 1));
        imem_instr = $urandom;
    endtask

    task automatic do_reset();
        resetn     = 1'b0;
        imem_ack   = 1'b1;
        imem_instr = $urandom;
        step();
        m_opcode  = 4'd0;
        m_op1     = 32'd0;
        m_op2     = 32'd0;
        m_retired = 32'd0;
        m_halted  = 1'b0;
        m_illegal = 1'b0;
        check_eq("reset", observed(), exp_idle(1'b0));
        resetn = 1'b1;
        noise();
        step();
    endtask

    task automatic hold_halt();
        for (int i = 0; i < 4; i++) begin
            noise();
            step();
            check_eq("halt_hold", observed(), exp_idle(1'b0));
        end
    endtask

    // abort: 0 = run to completion, 1 = reset during DECODE, 2 = reset during EXEC
    task automatic do_instr(input logic [31:0] ins, input int delay, input int abort);
        logic [3:0] m;
        logic       imc;
        logic       rg;
        logic       re;
        logic       rw;
        logic [1:0] pc;
        logic [1:0] wc;
        m = ins[31:28];
        check_eq("fetch", observed(), exp_idle(1'b1));
        for (int i = 0; i < delay; i++) begin
            imem_ack   = 1'b0;
            imem_instr = $urandom;
            step();
            check_eq("fetch_wait", observed(), exp_idle(1'b1));
        end
        imem_ack   = 1'b1;
        imem_instr = ins;
        step();
        noise();
        check_eq("decode", observed(), exp_idle(1'b0));
        if (abort == 1) begin
            do_reset();
            return;
        end
        if (m >= 4'd8) begin
            step();
            m_halted  = 1'b1;
            m_illegal = 1'b1;
            check_eq("illegal", observed(), exp_idle(1'b0));
            hold_halt();
            return;
        end
        m_opcode = ins[27:24];
        m_op1    = {27'd0, ins[23:19]};
        m_op2    = (m == 4'd0) ? {27'd0, ins[18:14]} : {13'd0, ins[18:0]};
        imc = 1'b0; rg = 1'b0; re = 1'b0; rw = 1'b0; pc = 2'd2; wc = 2'd0;
        case (m)
            4'd0: begin rg = 1'b1; pc = 2'd0; end
            4'd1: begin imc = 1'b1; rg = 1'b1; pc = 2'd0; end
            4'd2: begin wc = 2'd1; rg = 1'b1; pc = 2'd0; end
            4'd3: begin re = 1'b1; end
            4'd4: begin re = 1'b1; rw = 1'b1; pc = 2'd0; end
            4'd5: begin pc = 2'd1; end
            4'd6: begin pc = 2'd0; end
            default: begin pc = 2'd2; end
        endcase
        // an instruction retires in whichever cycle its PC step appears
        if (pc != 2'd2) m_retired = m_retired + 32'd1;
        step();
        noise();
        check_eq("exec", observed(), pack(1'b0, m_opcode, m_op1, m_op2, imc, rg, re, rw, pc, wc,
                                          m_retired, m_halted, m_illegal));
        if (abort == 2) begin
            do_reset();
            return;
        end
        if (m == 4'd3) begin
            m_retired = m_retired + 32'd1;
            step();
            noise();
            check_eq("mem", observed(), pack(1'b0, m_opcode, m_op1, m_op2, 1'b0, 1'b1, 1'b1, 1'b0,
                                             2'd0, 2'd2, m_retired, m_halted, m_illegal));
        end else if (m == 4'd7) begin
            m_retired = m_retired + 32'd1;
            m_halted  = 1'b1;
            step();
            check_eq("halt", observed(), exp_idle(1'b0));
            hold_halt();
            return;
        end
        step();
    endtask

    initial begin
        logic [31:0] ins;
        do_reset();
        do_instr(32'h1108_0005, 0, 0);
        do_instr(32'h3010_0040, 0, 0);
        do_instr(32'h5000_0020, 1, 0);
        do_instr(32'h4118_0123, 0, 0);
        do_instr(32'h0a21_c000, 4, 0);
        do_instr(32'h27ff_ffff, 2, 0);
        do_instr(32'h6000_0000, 0, 0);
        for (int n = 0; n < 60; n++) begin
            ins = $urandom;
            ins[31:28] = 4'($urandom_range(0, 6));
            do_instr(ins, $urandom_range(0, 3), 0);
        end
        do_instr(32'h7000_0000, 0, 0);
        do_reset();
        do_instr(32'h1108_0005, 0, 0);
        do_instr(32'hA123_4567, 2, 0);
        do_reset();
        do_instr(32'h0a21_c000, 0, 2);
        do_instr(32'h3010_0040, 1, 1);
        do_instr(32'h1108_0005, 0, 0);
        do_instr(32'hF000_0001, 0, 0);
        do_reset();
        do_instr(32'h3010_0040, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
